// File: rtl/sprite_compositor.sv
// Sprite/background compositor: resolves sprite priority and transparency, maps the
// winning index through a CPU-writable palette, and tracks sprite-to-sprite collisions.
module sprite_compositor #(
  parameter int NUM_SPR = 4,
  parameter int PIXW    = 4,
  parameter int COLRW   = 12,
  parameter int TRANSP  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SPR*PIXW-1:0] spr_pix,
  input  logic [NUM_SPR-1:0]      spr_drawing,
  input  logic [PIXW-1:0]         bg_pix,
  input  logic                    de_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    pal_req,
  input  logic [PIXW:0]           pal_addr,
  input  logic [COLRW-1:0]        pal_wdata,
  output logic                    pal_ack,
  input  logic                    coll_clr,
  output logic [NUM_SPR-1:0]      collision,
  output logic [COLRW-1:0]        rgb,
  output logic                    de,
  output logic                    hsync,
  output logic                    vsync
);

  localparam int PAL_N = 2 ** (PIXW + 1);

  // The palette is written on the edge that leaves IDLE; ACK is the one-cycle ack slot.
  typedef enum logic {IDLE, ACK} wr_state_t;

  wr_state_t              state_q, state_d;
  logic                   wr_en;
  logic [COLRW-1:0]       pal_q [PAL_N];
  logic [COLRW-1:0]       pal_d [PAL_N];

  logic [NUM_SPR-1:0]     opaque;
  logic                   multi;
  logic [NUM_SPR-1:0]     coll_q, coll_d;

  logic [PIXW:0]          idx_p1_q, idx_p1_d;
  logic                   de_p1_q, hs_p1_q, vs_p1_q;
  logic [COLRW-1:0]       rgb_p2_q, rgb_p2_d;
  logic                   de_p2_q, hs_p2_q, vs_p2_q;

  always_comb begin
    opaque = '0;
    for (int n = 0; n < NUM_SPR; n++) begin
      opaque[n] = spr_drawing[n] && (spr_pix[n*PIXW +: PIXW] != PIXW'(TRANSP));
    end
    // Clearing the lowest set bit leaves something only when two or more are set.
    multi = |(opaque & (opaque - NUM_SPR'(1)));
  end

  // Stage 1: priority resolve, lowest-numbered opaque sprite wins
  always_comb begin
    idx_p1_d = {1'b0, bg_pix};
    for (int n = NUM_SPR - 1; n >= 0; n--) begin
      if (opaque[n]) idx_p1_d = {1'b1, spr_pix[n*PIXW +: PIXW]};
    end
  end

  always_comb begin
    coll_d = (coll_clr ? '0 : coll_q) | ((de_in && multi) ? opaque : '0);
  end

  // Stage 2: palette lookup, blanked outside active video
  always_comb begin
    rgb_p2_d = de_p1_q ? pal_q[idx_p1_q] : '0;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pal_req && !de_in) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < PAL_N; i++) pal_d[i] = pal_q[i];
    if (wr_en) pal_d[pal_addr] = pal_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      coll_q   <= '0;
      idx_p1_q <= '0;
      de_p1_q  <= 1'b0;
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
      rgb_p2_q <= '0;
      de_p2_q  <= 1'b0;
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      coll_q   <= coll_d;
      idx_p1_q <= idx_p1_d;
      de_p1_q  <= de_in;
      hs_p1_q  <= hsync_in;
      vs_p1_q  <= vsync_in;
      rgb_p2_q <= rgb_p2_d;
      de_p2_q  <= de_p1_q;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_d[i];
    end
  end

  assign pal_ack   = (state_q == ACK);
  assign collision = coll_q;
  assign rgb       = rgb_p2_q;
  assign de        = de_p2_q;
  assign hsync     = hs_p2_q;
  assign vsync     = vs_p2_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: priority, blanking, deferred and back-to-back
// palette writes, collision flags and asynchronous reset.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] spr_pix;
  logic [3:0]  spr_drawing;
  logic [3:0]  bg_pix;
  logic        de_in, hsync_in, vsync_in;
  logic        pal_req;
  logic [4:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic        pal_ack;
  logic        coll_clr;
  logic [3:0]  collision;
  logic [11:0] rgb;
  logic        de, hsync, vsync;

  int checks   = 0;
  int failures = 0;

  sprite_compositor dut (
    .clk(clk), .rst(rst), .spr_pix(spr_pix), .spr_drawing(spr_drawing), .bg_pix(bg_pix),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .pal_req(pal_req),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_ack(pal_ack), .coll_clr(coll_clr),
    .collision(collision), .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pal_write(input logic [4:0] a, input logic [11:0] d);
    bit got;
    got = 1'b0;
    de_in = 1'b0; pal_addr = a; pal_wdata = d; pal_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = pal_ack;
    end
    pal_req = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL pal_write_ack addr=%h got=0 required=1", a);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    spr_pix = '0; spr_drawing = '0; bg_pix = '0;
    de_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    pal_req = 1'b0; pal_addr = '0; pal_wdata = '0; coll_clr = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({rgb, de, hsync, vsync, pal_ack, collision} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got rgb=%h de=%b hs=%b vs=%b ack=%b coll=%b required all 0",
               rgb, de, hsync, vsync, pal_ack, collision);
    end
    de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    pal_write(5'h13, 12'hF00);
    pal_write(5'h15, 12'h0F0);
    pal_write(5'h02, 12'h00F);
    de_in = 1'b1; spr_pix = 16'h0053; spr_drawing = 4'b0011; bg_pix = 4'h2;
    tick(); tick();
    checks++;
    if (rgb !== 12'hF00 || de !== 1'b1) begin
      failures++;
      $display("FAIL prio_spr0 got rgb=%h de=%b required rgb=f00 de=1", rgb, de);
    end
    spr_drawing = 4'b0010;
    tick(); tick();
    checks++;
    if (rgb !== 12'h0F0) begin
      failures++;
      $display("FAIL prio_spr1 got rgb=%h required 0f0", rgb);
    end
    spr_pix = 16'h0000; spr_drawing = 4'b0011;
    tick(); tick();
    checks++;
    if (rgb !== 12'h00F) begin
      failures++;
      $display("FAIL prio_transparent_bg got rgb=%h required 00f", rgb);
    end
  endtask

  task automatic test_blanking();
    logic exp_hs;
    de_in = 1'b0; spr_pix = 16'h0003; spr_drawing = 4'b0001;
    tick(); tick();
    checks++;
    if (rgb !== 12'h000 || de !== 1'b0) begin
      failures++;
      $display("FAIL blank_rgb got rgb=%h de=%b required rgb=000 de=0", rgb, de);
    end
    for (int i = 0; i < 102; i++) begin
      hsync_in = (i < 96);
      tick();
      exp_hs = (i >= 1) && (i - 1 < 96);
      checks++;
      if (hsync !== exp_hs) begin
        failures++;
        $display("FAIL hsync_delay cycle=%0d got=%b required=%b", i, hsync, exp_hs);
      end
    end
  endtask

  task automatic test_deferred_write();
    de_in = 1'b1; spr_pix = 16'h0003; spr_drawing = 4'b0001;
    pal_addr = 5'h13; pal_wdata = 12'hABC; pal_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (pal_ack !== 1'b0) begin
        failures++;
        $display("FAIL defer_no_ack cycle=%0d got=%b required=0", i, pal_ack);
      end
      if (i >= 1) begin
        checks++;
        if (rgb !== 12'hF00) begin
          failures++;
          $display("FAIL defer_colour_kept cycle=%0d got=%h required=f00", i, rgb);
        end
      end
    end
    de_in = 1'b0;
    checks++;
    if (pal_ack !== 1'b0) begin
      failures++;
      $display("FAIL defer_ack_early got=%b required=0", pal_ack);
    end
    tick();
    checks++;
    if (pal_ack !== 1'b1) begin
      failures++;
      $display("FAIL defer_ack got=%b required=1", pal_ack);
    end
    pal_req = 1'b0;
    tick();
    checks++;
    if (pal_ack !== 1'b0) begin
      failures++;
      $display("FAIL defer_ack_width got=%b required=0", pal_ack);
    end
    tick();
    checks++;
    if (pal_ack !== 1'b0) begin
      failures++;
      $display("FAIL defer_extra_ack got=%b required=0", pal_ack);
    end
    de_in = 1'b1;
    tick(); tick();
    checks++;
    if (rgb !== 12'hABC) begin
      failures++;
      $display("FAIL defer_new_colour got rgb=%h required abc", rgb);
    end
  endtask

  task automatic test_back_to_back();
    de_in = 1'b0; spr_drawing = 4'b0000;
    pal_req = 1'b1; pal_addr = 5'h04; pal_wdata = 12'h123;
    tick();
    checks++;
    if (pal_ack !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack1 got=%b required=1", pal_ack);
    end
    pal_addr = 5'h05; pal_wdata = 12'h456;
    tick();
    checks++;
    if (pal_ack !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got=%b required=0", pal_ack);
    end
    tick();
    checks++;
    if (pal_ack !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack2 got=%b required=1", pal_ack);
    end
    pal_req = 1'b0;
    tick();
    tick();
    checks++;
    if (pal_ack !== 1'b0) begin
      failures++;
      $display("FAIL b2b_extra_ack got=%b required=0", pal_ack);
    end
    de_in = 1'b1; bg_pix = 4'h4;
    tick();
    bg_pix = 4'h5;
    tick();
    checks++;
    if (rgb !== 12'h123) begin
      failures++;
      $display("FAIL b2b_entry4 got rgb=%h required 123", rgb);
    end
    tick();
    checks++;
    if (rgb !== 12'h456) begin
      failures++;
      $display("FAIL b2b_entry5 got rgb=%h required 456", rgb);
    end
  endtask

  task automatic test_collision();
    spr_drawing = 4'b0000; coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0;
    checks++;
    if (collision !== 4'b0000) begin
      failures++;
      $display("FAIL coll_initial_clear got=%b required=0000", collision);
    end
    de_in = 1'b1; spr_pix = 16'h7020; spr_drawing = 4'b1010;
    tick();
    checks++;
    if (collision !== 4'b1010) begin
      failures++;
      $display("FAIL coll_set got=%b required=1010", collision);
    end
    spr_drawing = 4'b0000;
    tick(); tick();
    checks++;
    if (collision !== 4'b1010) begin
      failures++;
      $display("FAIL coll_sticky got=%b required=1010", collision);
    end
    coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0;
    checks++;
    if (collision !== 4'b0000) begin
      failures++;
      $display("FAIL coll_clear got=%b required=0000", collision);
    end
    de_in = 1'b0; spr_drawing = 4'b1010;
    tick();
    checks++;
    if (collision !== 4'b0000) begin
      failures++;
      $display("FAIL coll_blank_ignored got=%b required=0000", collision);
    end
    de_in = 1'b1;
    tick();
    spr_pix = 16'h0601; spr_drawing = 4'b0101; coll_clr = 1'b1;
    tick();
    coll_clr = 1'b0; spr_drawing = 4'b0000;
    checks++;
    if (collision !== 4'b0101) begin
      failures++;
      $display("FAIL coll_set_beats_clr got=%b required=0101", collision);
    end
  endtask

  task automatic test_reset_midwrite();
    de_in = 1'b1; spr_pix = 16'h0003; spr_drawing = 4'b0001; bg_pix = 4'h2;
    pal_req = 1'b1; pal_addr = 5'h02; pal_wdata = 12'hFFF;
    tick(); tick();
    checks++;
    if (rgb !== 12'hABC || de !== 1'b1 || collision !== 4'b0101) begin
      failures++;
      $display("FAIL pre_reset got rgb=%h de=%b coll=%b required rgb=abc de=1 coll=0101",
               rgb, de, collision);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rgb, de, hsync, vsync, pal_ack, collision} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset got rgb=%h de=%b hs=%b vs=%b ack=%b coll=%b required all 0",
               rgb, de, hsync, vsync, pal_ack, collision);
    end
    pal_req = 1'b0; de_in = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pal_ack !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_ack cycle=%0d got=%b required=0", i, pal_ack);
      end
    end
    de_in = 1'b1;
    tick(); tick();
    checks++;
    if (rgb !== 12'h000 || de !== 1'b1) begin
      failures++;
      $display("FAIL reset_pal_spr got rgb=%h de=%b required rgb=000 de=1", rgb, de);
    end
    spr_drawing = 4'b0000;
    tick(); tick();
    checks++;
    if (rgb !== 12'h000 || de !== 1'b1) begin
      failures++;
      $display("FAIL reset_pal_bg got rgb=%h de=%b required rgb=000 de=1", rgb, de);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_blanking();
    test_deferred_write();
    test_back_to_back();
    test_collision();
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
